// File: rtl/hack_clk_pkg.sv
// Shared definitions for the CPU clock controller: controller states and
// default sizing constants.
package hack_clk_pkg;

    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    localparam int DEF_POR_TICKS = 16;
    localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/cpu_clock_ctrl_if.sv
// Control/status bundle between the front-panel/clock-divider side (master)
// and the CPU clock controller (slave).
interface cpu_clock_ctrl_if
    import hack_clk_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             tick;
    logic             run_btn;
    logic             halt_btn;
    logic             step_btn;
    logic             cpu_ce;
    logic             cpu_reset;
    logic             running;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output tick, run_btn, halt_btn, step_btn,
        input  cpu_ce, cpu_reset, running, cycle_count
    );

    modport slave (
        input  tick, run_btn, halt_btn, step_btn,
        output cpu_ce, cpu_reset, running, cycle_count
    );
endinterface

// File: rtl/cpu_clock_ctrl_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector; a held level yields a
// single one-clk press pulse, registered so it appears 3 clk after the raw rise.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);
    logic r_sync1;
    logic r_sync2;
    logic r_edge;
    logic r_press;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
            r_press <= r_sync2 & ~r_edge;
        end
    end

    assign o_press = r_press;
endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable controller: power-on reset hold, run/halt/single-step
// control from debounced front-panel buttons, and a CPU cycle counter.
module cpu_clock_ctrl
    import hack_clk_pkg::*;
#(
    parameter int POR_TICKS = DEF_POR_TICKS,
    parameter bit START_RUN = 1'b1,
    parameter int CNT_W     = DEF_CNT_W
)(
    input logic             clk,
    input logic             reset,
    cpu_clock_ctrl_if.slave bus
);
    localparam logic [7:0] POR_LAST = 8'(POR_TICKS - 1);
    localparam state_t     POR_EXIT = START_RUN ? ST_RUN : ST_HALT;

    logic             w_runPress;
    logic             w_haltPress;
    logic             w_stepPress;
    state_t           r_state;
    state_t           w_stateNext;
    logic [7:0]       r_porCnt;
    logic [7:0]       w_porCntNext;
    logic             w_ceNext;
    logic             r_ce;
    logic             r_cpuReset;
    logic             r_running;
    logic [CNT_W-1:0] r_count;

    sync_edge u_runSync (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (bus.run_btn),
        .o_press (w_runPress)
    );

    sync_edge u_haltSync (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (bus.halt_btn),
        .o_press (w_haltPress)
    );

    sync_edge u_stepSync (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (bus.step_btn),
        .o_press (w_stepPress)
    );

    // Halt always wins; a press that changes state swallows a tick in the same clk.
    always_comb begin
        w_stateNext  = r_state;
        w_porCntNext = r_porCnt;
        w_ceNext     = 1'b0;
        case (r_state)
            ST_POR: begin
                if (bus.tick) begin
                    if (r_porCnt == POR_LAST) begin
                        w_stateNext  = POR_EXIT;
                        w_porCntNext = 8'd0;
                    end else begin
                        w_porCntNext = r_porCnt + 8'd1;
                    end
                end
            end
            ST_RUN: begin
                if (w_haltPress) begin
                    w_stateNext = ST_HALT;
                end else begin
                    w_ceNext = bus.tick & ~r_ce;
                end
            end
            ST_HALT: begin
                if (!w_haltPress) begin
                    if (w_runPress) begin
                        w_stateNext = ST_RUN;
                    end else if (w_stepPress) begin
                        w_stateNext = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                if (w_haltPress) begin
                    w_stateNext = ST_HALT;
                end else if (bus.tick && !r_ce) begin
                    w_ceNext    = 1'b1;
                    w_stateNext = ST_HALT;
                end
            end
            default: begin
                w_stateNext = ST_POR;
            end
        endcase
    end

    // cpu_reset follows the current state, so it drops one clk after leaving POR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_POR;
            r_porCnt   <= 8'd0;
            r_ce       <= 1'b0;
            r_cpuReset <= 1'b1;
            r_running  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_porCnt   <= w_porCntNext;
            r_ce       <= w_ceNext;
            r_cpuReset <= (r_state == ST_POR);
            r_running  <= (w_stateNext == ST_RUN);
            if (w_ceNext) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign bus.cpu_ce      = r_ce;
    assign bus.cpu_reset   = r_cpuReset;
    assign bus.running     = r_running;
    assign bus.cycle_count = r_count;
endmodule
